// File: rtl/calc_port_responder.sv
// calc_port_responder: responder end of the calc request/response protocol for one port.
// A two-cycle capture feeds a request FIFO. An executor drains it and runs add, sub, or a serial shift.
module calc_port_responder #(
    parameter int CALC_CMD_WIDTH  = 4,
    parameter int CALC_DATA_WIDTH = 32,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       PClk,
    input  logic                       Rst,
    input  logic [CALC_CMD_WIDTH-1:0]  req_cmd_in,
    input  logic [CALC_DATA_WIDTH-1:0] req_data_in,
    input  logic [1:0]                 req_tag_in,
    output logic [1:0]                 out_resp,
    output logic [CALC_DATA_WIDTH-1:0] out_data,
    output logic [1:0]                 out_tag,
    output logic                       req_full,
    output logic [7:0]                 drop_cnt
);
    localparam int W    = CALC_DATA_WIDTH;
    localparam int CW   = CALC_CMD_WIDTH;
    localparam int SHW  = $clog2(W);
    localparam int PTRW = $clog2(FIFO_DEPTH);
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);

    localparam logic [CW-1:0] CMD_ADD = CW'(1);
    localparam logic [CW-1:0] CMD_SUB = CW'(2);
    localparam logic [CW-1:0] CMD_SHL = CW'(5);
    localparam logic [CW-1:0] CMD_SHR = CW'(6);
    localparam logic [1:0]    RESP_OK  = 2'd1;
    localparam logic [1:0]    RESP_ERR = 2'd2;

    typedef struct packed {
        logic [CW-1:0] cmd;
        logic [1:0]    tag;
        logic [W-1:0]  op1;
        logic [W-1:0]  op2;
    } entry_t;

    typedef enum logic {CAP_IDLE, CAP_OP2} cap_state_t;
    typedef enum logic {EX_IDLE, EX_SHIFT} ex_state_t;

    cap_state_t cap_state, cap_next;
    ex_state_t  ex_state, ex_next;

    logic [CW-1:0]   cap_cmd;
    logic [1:0]      cap_tag;
    logic [W-1:0]    cap_op1;
    entry_t          mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;
    logic            push, push_ok, pop, drop;
    entry_t          head;
    logic [W:0]      sum_ext;
    logic [W-1:0]    sh_val;
    logic [SHW-1:0]  sh_cnt;
    logic            sh_left;
    logic [1:0]      sh_tag;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    // ---------------- capture FSM ----------------
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) cap_state <= CAP_IDLE;
        else     cap_state <= cap_next;
    end

    // NOTE: next-state is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            CAP_IDLE: if (req_cmd_in != '0) cap_next = CAP_OP2;
            CAP_OP2:  cap_next = CAP_IDLE;
            default:  cap_next = CAP_IDLE;
        endcase
    end

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            cap_cmd <= '0;
            cap_tag <= '0;
            cap_op1 <= '0;
        end else if (cap_state == CAP_IDLE && req_cmd_in != '0) begin
            cap_cmd <= req_cmd_in;
            cap_tag <= req_tag_in;
            cap_op1 <= req_data_in;
        end
    end

    // ---------------- request FIFO ----------------
    assign req_full = (count == CNTW'(FIFO_DEPTH));
    assign push     = (cap_state == CAP_OP2);
    assign pop      = (ex_state == EX_IDLE) && (count != '0);
    assign push_ok  = push && (!req_full || pop);
    assign drop     = push && req_full && !pop;
    assign head     = mem[rd_ptr];

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            if (push_ok && !pop)      count <= count + CNTW'(1);
            else if (pop && !push_ok) count <= count - CNTW'(1);
            if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // NOTE: FIFO storage has no reset; count alone decides which entries are valid.
    always_ff @(posedge PClk) begin
        if (push_ok) mem[wr_ptr] <= '{cmd: cap_cmd, tag: cap_tag, op1: cap_op1, op2: req_data_in};
    end

    // ---------------- execution FSM ----------------
    assign sum_ext = {1'b0, head.op1} + {1'b0, head.op2};

    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) ex_state <= EX_IDLE;
        else     ex_state <= ex_next;
    end

    always_comb begin
        ex_next = ex_state;
        case (ex_state)
            EX_IDLE:  if (pop && (head.cmd == CMD_SHL || head.cmd == CMD_SHR)) ex_next = EX_SHIFT;
            EX_SHIFT: if (sh_cnt == '0) ex_next = EX_IDLE;
            default:  ex_next = EX_IDLE;
        endcase
    end

    // Response registers default to zero so each result is visible for exactly one cycle.
    always_ff @(posedge PClk or posedge Rst) begin
        if (Rst) begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            sh_val   <= '0;
            sh_cnt   <= '0;
            sh_left  <= 1'b0;
            sh_tag   <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            out_tag  <= '0;
            case (ex_state)
                EX_IDLE: if (pop) begin
                    case (head.cmd)
                        CMD_ADD: begin
                            out_tag <= head.tag;
                            if (sum_ext[W]) out_resp <= RESP_ERR;
                            else begin
                                out_resp <= RESP_OK;
                                out_data <= sum_ext[W-1:0];
                            end
                        end
                        CMD_SUB: begin
                            out_tag <= head.tag;
                            if (head.op2 > head.op1) out_resp <= RESP_ERR;
                            else begin
                                out_resp <= RESP_OK;
                                out_data <= head.op1 - head.op2;
                            end
                        end
                        CMD_SHL, CMD_SHR: begin
                            sh_val  <= head.op1;
                            sh_cnt  <= head.op2[SHW-1:0];
                            sh_left <= (head.cmd == CMD_SHL);
                            sh_tag  <= head.tag;
                        end
                        default: begin
                            out_tag  <= head.tag;
                            out_resp <= RESP_ERR;
                        end
                    endcase
                end
                EX_SHIFT: begin
                    if (sh_cnt != '0) begin
                        sh_val <= sh_left ? (sh_val << 1) : (sh_val >> 1);
                        sh_cnt <= sh_cnt - SHW'(1);
                    end else begin
                        out_resp <= RESP_OK;
                        out_data <= sh_val;
                        out_tag  <= sh_tag;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_port_responder.sv
// Scoreboard bench for calc_port_responder: directed protocol cases plus randomized requests
// checked against an arithmetic reference model.
module tb_calc_port_responder;
    logic        PClk = 1'b0;
    logic        Rst;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic [1:0]  out_resp;
    logic [31:0] out_data;
    logic [1:0]  out_tag;
    logic        req_full;
    logic [7:0]  drop_cnt;

    calc_port_responder #(.CALC_CMD_WIDTH(4), .CALC_DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
        .PClk(PClk), .Rst(Rst),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .req_full(req_full), .drop_cnt(drop_cnt)
    );

    always #5 PClk = ~PClk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   resp_count = 0;
    int   last_resp_cyc = 0;

    always @(posedge PClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the result each command should produce, from plain arithmetic.
    function automatic exp_t model(input logic [3:0] cmd, input logic [1:0] tag,
                                   input logic [31:0] op1, input logic [31:0] op2);
        exp_t e;
        logic [63:0] s;
        e.tag  = tag;
        e.resp = 2'd2;
        e.data = 32'd0;
        case (cmd)
            4'd1: begin
                s = {32'd0, op1} + {32'd0, op2};
                if (s <= 64'hFFFF_FFFF) begin e.resp = 2'd1; e.data = s[31:0]; end
            end
            4'd2: if (op1 >= op2) begin e.resp = 2'd1; e.data = op1 - op2; end
            4'd5: begin e.resp = 2'd1; e.data = op1 << (op2 % 32); end
            4'd6: begin e.resp = 2'd1; e.data = op1 >> (op2 % 32); end
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: every response is popped against the scoreboard; idle cycles must be all-zero.
    always @(negedge PClk) begin
        if (!Rst) begin
            if (out_resp != 2'd0) begin
                resp_count++;
                last_resp_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp: got resp=%0d data=%0h tag=%0d, none expected",
                             out_resp, out_data, out_tag);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("response", 64'({out_resp, out_tag, out_data}), 64'({e.resp, e.tag, e.data}));
                end
            end else begin
                check("idle_zero", 64'({out_tag, out_data}), 64'd0);
            end
        end
    end

    task automatic step();
        @(negedge PClk);
        #1;
    endtask

    // Two-cycle request; cmd/tag in the operand-2 cycle carry junk that must be ignored.
    task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] op1,
                        input logic [31:0] op2, input bit accepted, output int e_cyc);
        req_cmd_in  = cmd;
        req_tag_in  = tag;
        req_data_in = op1;
        e_cyc = cyc + 1;
        if (cmd != 4'd0 && accepted) exp_q.push_back(model(cmd, tag, op1, op2));
        step();
        req_cmd_in  = (cmd != 4'd0) ? 4'($urandom_range(1, 15)) : 4'd0;
        req_tag_in  = 2'($urandom_range(0, 3));
        req_data_in = op2;
        step();
        req_cmd_in  = 4'd0;
        req_tag_in  = 2'd0;
        req_data_in = $urandom;
    endtask

    task automatic wait_resp(input string name, input int target, input int budget);
        int n = 0;
        while (resp_count < target && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(resp_count >= target), 64'd1);
    endtask

    int e_cyc, base;
    logic [3:0] cmd_tab [10] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd3, 4'd7, 4'd15};

    initial begin
        Rst = 1'b1;
        req_cmd_in = 4'd0;
        req_data_in = 32'd0;
        req_tag_in = 2'd0;
        repeat (3) step();
        check("reset_outputs", 64'({out_resp, out_tag, out_data, req_full, drop_cnt}), 64'd0);
        Rst = 1'b0;
        step();

        // add 5+7 tag 1: result visible right after edge E+2
        base = resp_count;
        send(4'd1, 2'd1, 32'd5, 32'd7, 1'b1, e_cyc);
        wait_resp("wait_add", base + 1, 20);
        check("add_latency", 64'(last_resp_cyc - e_cyc), 64'd2);

        // carry-out add, underflow sub
        base = resp_count;
        send(4'd1, 2'd2, 32'hFFFF_FFFF, 32'd1, 1'b1, e_cyc);
        send(4'd2, 2'd0, 32'd3, 32'd5, 1'b1, e_cyc);
        wait_resp("wait_ovf", base + 2, 20);
        check("sub_latency", 64'(last_resp_cyc - e_cyc), 64'd2);

        // shl 1 by 4 -> 0x10 at E+7; shr 0x80 by 0 -> 0x80 at E+3
        base = resp_count;
        send(4'd5, 2'd3, 32'h1, 32'd4, 1'b1, e_cyc);
        wait_resp("wait_shl", base + 1, 30);
        check("shl_latency", 64'(last_resp_cyc - e_cyc), 64'd7);
        base = resp_count;
        send(4'd6, 2'd0, 32'h80, 32'd0, 1'b1, e_cyc);
        wait_resp("wait_shr0", base + 1, 30);
        check("shr0_latency", 64'(last_resp_cyc - e_cyc), 64'd3);

        // invalid command
        base = resp_count;
        send(4'd4, 2'd1, 32'd9, 32'd9, 1'b1, e_cyc);
        wait_resp("wait_inv", base + 1, 20);

        // cmd 0 stream: nothing captured, nothing answered
        base = resp_count;
        repeat (12) begin
            req_cmd_in = 4'd0;
            req_data_in = $urandom;
            req_tag_in = 2'($urandom_range(0, 3));
            step();
        end
        check("nop_no_resp", 64'(resp_count), 64'(base));
        check("nop_not_full", 64'(req_full), 64'd0);

        // long shift blocks the executor; fifth queued add is dropped
        base = resp_count;
        send(4'd5, 2'd0, 32'h1, 32'd31, 1'b1, e_cyc);
        for (int i = 0; i < 5; i++)
            send(4'd1, 2'(i + 1), 32'(10 + i), 32'd20, i < 4, e_cyc);
        check("full_set", 64'(req_full), 64'd1);
        check("drop_cnt_1", 64'(drop_cnt), 64'd1);
        wait_resp("wait_full_drain", base + 5, 100);
        check("full_clear", 64'(req_full), 64'd0);
        check("full_q_empty", 64'(exp_q.size()), 64'd0);

        // reset during EX_SHIFT: cleared at once, no late response
        send(4'd5, 2'd2, 32'h1, 32'd20, 1'b1, e_cyc);
        repeat (4) step();
        Rst = 1'b1;
        exp_q.delete();
        step();
        check("rst_mid_outputs", 64'({out_resp, out_tag, out_data, req_full}), 64'd0);
        check("rst_drop_clear", 64'(drop_cnt), 64'd0);
        Rst = 1'b0;
        base = resp_count;
        repeat (40) step();
        check("rst_no_late_resp", 64'(resp_count), 64'(base));
        send(4'd1, 2'd1, 32'd100, 32'd23, 1'b1, e_cyc);
        wait_resp("wait_post_rst_add", base + 1, 20);
        check("post_rst_latency", 64'(last_resp_cyc - e_cyc), 64'd2);

        // randomized traffic, outstanding kept below FIFO depth so nothing drops
        for (int i = 0; i < 80; i++) begin
            logic [3:0]  c;
            logic [31:0] a, b;
            int n;
            n = 0;
            while (exp_q.size() >= 3 && n < 200) begin
                step();
                n++;
            end
            if (n >= 200) check("rand_backlog_timeout", 64'(exp_q.size()), 64'd0);
            c = cmd_tab[$urandom_range(0, 9)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a = 32'($urandom_range(0, 15));
                b = 32'($urandom_range(0, 15));
            end
            send(c, 2'($urandom_range(0, 3)), a, b, 1'b1, e_cyc);
            repeat ($urandom_range(0, 2)) step();
        end
        begin
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 500) begin
                step();
                n++;
            end
        end
        check("final_q_empty", 64'(exp_q.size()), 64'd0);
        check("final_no_drops", 64'(drop_cnt), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
